hwag_channel_scheduler: RTL and testbench
=========================================

HWAG_CHANNEL_SCHEDULER -- requirements
Module: hwag_channel_scheduler

Interface
REQ-001 SHALL have parameter CH_NUM, default 8, number of output channels (power of two, 2..16).
REQ-002 SHALL have parameter ACNT_WIDTH, default 24, angle width.
REQ-003 SHALL have parameter MAX_ACR, default 3839, maximum legal angle value.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port ena  input  1  angle generator synchronised (hwag_start); 0 = stop scheduling.
REQ-007 SHALL have port acnt  input  ACNT_WIDTH  current angle from the angle counter.
REQ-008 SHALL have port wr_valid  input  1  configuration write request.
REQ-009 SHALL have port wr_ready  output  1  write accepted this cycle when high with wr_valid.
REQ-010 SHALL have port wr_addr  input  log2(CH_NUM)  target channel.
REQ-011 SHALL have port wr_sel  input  2  register select: 0 set angle, 1 reset angle, 2 enable (wr_data[0]), 3 reserved.
REQ-012 SHALL have port wr_data  input  ACNT_WIDTH  write data.
REQ-013 SHALL have port wr_err  output  1  one-cycle pulse: accepted write rejected (angle > MAX_ACR).
REQ-014 SHALL have port ch_out  output  CH_NUM  registered channel outputs.
REQ-015 SHALL have port round_done  output  1  one-cycle pulse when the last channel of a scan round is committed.

Function
REQ-016 SHALL hold per channel: set angle, reset angle (ACNT_WIDTH each), enable bit.
REQ-017 SHALL scan channels with a single shared comparator: index 0..CH_NUM-1, +1 per clock while ena=1, wraps to 0.
REQ-018 SHALL latch acnt into an angle snapshot in the cycle the index is 0; all channels of one round compare against that snapshot.
REQ-019 SHALL pipeline two stages: stage 1 reads channel registers and compares; stage 2 writes ch_out[idx] one clock later.
REQ-020 SHALL evaluate window: set<reset -> active when set <= snap < reset; set>reset (wrap) -> active when snap >= set or snap < reset; set==reset -> inactive.
REQ-021 SHALL drive ch_out[i]=0 whenever channel enable bit is 0, committed on that channel's stage 2.
REQ-022 SHALL reflect an acnt change in ch_out within 2*CH_NUM+2 clocks.
REQ-023 SHALL pulse round_done in the cycle stage 2 commits channel CH_NUM-1.
REQ-024 SHALL deassert wr_ready only when wr_addr equals the channel currently in stage 1; otherwise wr_ready=1.
REQ-025 SHALL complete an accepted write (wr_valid & wr_ready) in the next clock; the new value is used from the channel's next stage-1 visit.
REQ-026 SHALL, for wr_sel 0/1 with wr_data > MAX_ACR, leave the register unchanged and pulse wr_err one clock after acceptance.
REQ-027 SHALL accept wr_sel 3 with no register change and no wr_err.
REQ-028 SHALL, when ena falls, clear ch_out to 0 on the next clock, reset index to 0, flush the pipeline, suppress round_done; configuration is kept.
REQ-029 SHALL, when ena rises, start at index 0 with a fresh snapshot; first round_done after CH_NUM+1 clocks.
REQ-030 SHALL accept configuration writes regardless of ena.

Reset
REQ-031 SHALL, on rst=0, asynchronously clear ch_out, round_done, wr_err, index, snapshot, pipeline, all set/reset angles and all enable bits to 0.
REQ-032 SHALL hold wr_ready=1 during reset and drop the write while rst=0.
REQ-033 SHALL resume scanning on the first clock after rst deasserts if ena=1.

Verification
REQ-034 SHALL cover: ch2 set=100 reset=200 en=1, acnt=150 -> ch_out[2]=1 within 18 clocks; acnt=200 -> 0.
REQ-035 SHALL cover wrap: ch5 set=3700 reset=50, acnt=3800 -> 1, acnt=20 -> 1, acnt=60 -> 0.
REQ-036 SHALL cover collision: write to channel in stage 1 -> wr_ready=0 one cycle, then accepted; value 4000 -> wr_err pulse, register unchanged.
REQ-037 SHALL cover ena drop with ch_out=8'hFF -> ch_out=0 next clock, no round_done until re-enable.
REQ-038 SHALL cover rst asserted mid-round -> all outputs 0 immediately; after release with ena=1 and no writes, ch_out stays 0.
REQ-039 SHALL cover set==reset=300, acnt sweep 0..3839 -> channel never active.

Source files
------------

// File: rtl/hwag_channel_scheduler.sv
// hwag_channel_scheduler: angle-window scheduler that scans all channels through one shared comparator
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-low reset
//   ena        - angle generator synchronised; low stops scanning and clears outputs
//   acnt       - current angle from the angle counter
//   wr_valid   - configuration write request
//   wr_ready   - low only while the addressed channel occupies stage 1
//   wr_addr    - target channel
//   wr_sel     - 0 set angle, 1 reset angle, 2 enable (wr_data[0]), 3 reserved
//   wr_data    - write data
//   wr_err     - one-cycle pulse after an accepted angle write above MAX_ACR
//   ch_out     - registered channel outputs
//   round_done - one-cycle pulse when the last channel of a round is committed
module hwag_channel_scheduler #(
    parameter int CH_NUM     = 8,
    parameter int ACNT_WIDTH = 24,
    parameter int MAX_ACR    = 3839,
    localparam int IW        = $clog2(CH_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [ACNT_WIDTH-1:0] acnt,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [IW-1:0]         wr_addr,
    input  logic [1:0]            wr_sel,
    input  logic [ACNT_WIDTH-1:0] wr_data,
    output logic                  wr_err,
    output logic [CH_NUM-1:0]     ch_out,
    output logic                  round_done
);
    logic [ACNT_WIDTH-1:0] set_q [CH_NUM];
    logic [ACNT_WIDTH-1:0] rang_q [CH_NUM];
    logic [CH_NUM-1:0]     en_q;
    logic [IW-1:0]         idx_q;
    logic [ACNT_WIDTH-1:0] snap_q, snap_d;
    logic                  p_vld_q, p_hit_q;
    logic [IW-1:0]         p_idx_q;
    logic [CH_NUM-1:0]     ch_out_q;
    logic                  round_done_q, wr_err_q;
    logic [ACNT_WIDTH-1:0] cur_set, cur_rang;
    logic                  in_win, hit_d, wr_acc, ang_bad;

    // Channel 0 compares against the live angle; the rest of the round reuses the latched copy.
    always_comb begin
        snap_d   = (idx_q == '0) ? acnt : snap_q;
        cur_set  = set_q[idx_q];
        cur_rang = rang_q[idx_q];
        in_win   = (cur_set < cur_rang) ? (snap_d >= cur_set && snap_d < cur_rang) :
                   (cur_set > cur_rang) ? (snap_d >= cur_set || snap_d < cur_rang) : 1'b0;
        hit_d    = en_q[idx_q] & in_win;
    end

    // Held high in reset so a requester never stalls; writes are dropped by the reset anyway.
    assign wr_ready = ~rst | ~(ena & (wr_addr == idx_q));
    assign wr_acc   = wr_valid & wr_ready;
    assign ang_bad  = ~wr_sel[1] & (wr_data > ACNT_WIDTH'(MAX_ACR));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CH_NUM; i++) begin
                set_q[i]  <= '0;
                rang_q[i] <= '0;
            end
            en_q         <= '0;
            idx_q        <= '0;
            snap_q       <= '0;
            p_vld_q      <= 1'b0;
            p_hit_q      <= 1'b0;
            p_idx_q      <= '0;
            ch_out_q     <= '0;
            round_done_q <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            wr_err_q <= wr_acc & ang_bad;
            if (wr_acc && !ang_bad) begin
                if (wr_sel == 2'd0) set_q[wr_addr] <= wr_data;
                if (wr_sel == 2'd1) rang_q[wr_addr] <= wr_data;
                if (wr_sel == 2'd2) en_q[wr_addr] <= wr_data[0];
            end
            if (ena) begin
                idx_q        <= idx_q + IW'(1);
                snap_q       <= snap_d;
                p_vld_q      <= 1'b1;
                p_idx_q      <= idx_q;
                p_hit_q      <= hit_d;
                if (p_vld_q) ch_out_q[p_idx_q] <= p_hit_q;
                round_done_q <= p_vld_q && (p_idx_q == IW'(CH_NUM - 1));
            end else begin
                idx_q        <= '0;
                p_vld_q      <= 1'b0;
                ch_out_q     <= '0;
                round_done_q <= 1'b0;
            end
        end
    end

    assign ch_out     = ch_out_q;
    assign round_done = round_done_q;
    assign wr_err     = wr_err_q;
endmodule

// File: tb/tb_hwag_channel_scheduler.sv
// tb_hwag_channel_scheduler: directed self-checking bench for hwag_channel_scheduler
module tb_hwag_channel_scheduler;
    localparam int CH = 8;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ena = 1'b0;
    logic [AW-1:0] acnt = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [2:0]    wr_addr = '0;
    logic [1:0]    wr_sel = '0;
    logic [AW-1:0] wr_data = '0;
    logic          wr_err;
    logic [CH-1:0] ch_out;
    logic          round_done;
    int            n_run = 0;
    int            n_fail = 0;
    logic          seen, seen4;

    hwag_channel_scheduler #(.CH_NUM(CH), .ACNT_WIDTH(AW), .MAX_ACR(3839)) dut (
        .clk(clk), .rst(rst), .ena(ena), .acnt(acnt),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_sel(wr_sel), .wr_data(wr_data), .wr_err(wr_err),
        .ch_out(ch_out), .round_done(round_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int s, input int d);
        wr_valid = 1'b1;
        wr_addr  = 3'(a);
        wr_sel   = 2'(s);
        wr_data  = AW'(d);
        #1;
        for (int k = 0; k < 4 && !wr_ready; k++) tick(1);
        if (!wr_ready) check("wr_timeout", 32'(wr_ready), 32'd1);
        tick(1);
        wr_valid = 1'b0;
    endtask

    task automatic settle(input int a, input logic [31:0] e, input string tag);
        acnt = AW'(a);
        tick(2 * CH + 2);
        check(tag, 32'(ch_out), e);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(2);
        check("rst_ch_out", 32'(ch_out), 32'h0);
        check("rst_round_done", 32'(round_done), 32'h0);
        check("rst_wr_err", 32'(wr_err), 32'h0);
        check("rst_wr_ready", 32'(wr_ready), 32'h1);
        rst = 1'b1;
        tick(1);
        wr(2, 0, 100);  wr(2, 1, 200);  wr(2, 2, 1);
        wr(5, 0, 3700); wr(5, 1, 50);   wr(5, 2, 1);
        wr(3, 0, 300);  wr(3, 1, 300);  wr(3, 2, 1);
        acnt = AW'(150);
        ena  = 1'b1;
        tick(8);
        check("rd_not_yet", 32'(round_done), 32'h0);
        tick(1);
        check("rd_first", 32'(round_done), 32'h1);
        tick(1);
        check("rd_pulse", 32'(round_done), 32'h0);
        tick(16);
        check("win_inside", 32'(ch_out), 32'h04);
        settle(200,  32'h00, "win_reset_edge");
        settle(100,  32'h04, "win_set_edge");
        settle(199,  32'h04, "win_last");
        settle(3800, 32'h20, "wrap_high");
        settle(20,   32'h20, "wrap_low");
        settle(60,   32'h00, "wrap_out");
        settle(3700, 32'h20, "wrap_set_edge");
        settle(50,   32'h00, "wrap_reset_edge");
        wr(1, 0, 500); wr(1, 1, 600); wr(1, 2, 1);
        settle(550, 32'h02, "ch1_on");
        settle(700, 32'h00, "ch1_off");
        for (int k = 0; k < 20 && !round_done; k++) tick(1);
        check("rd_sync", 32'(round_done), 32'h1);
        wr_valid = 1'b1;
        wr_addr  = 3'd1;
        wr_sel   = 2'd1;
        wr_data  = AW'(4000);
        #1;
        check("coll_busy", 32'(wr_ready), 32'h0);
        tick(1);
        check("coll_free", 32'(wr_ready), 32'h1);
        tick(1);
        wr_valid = 1'b0;
        check("err_pulse", 32'(wr_err), 32'h1);
        tick(1);
        check("err_clear", 32'(wr_err), 32'h0);
        settle(700, 32'h00, "err_unchanged");
        wr(1, 3, 4000);
        check("sel3_noerr", 32'(wr_err), 32'h0);
        settle(700, 32'h00, "sel3_nochange");
        wr(1, 1, 3839);
        check("max_noerr", 32'(wr_err), 32'h0);
        settle(700, 32'h02, "max_accept");
        wr(1, 2, 0);
        settle(700, 32'h00, "disable");
        for (int c = 0; c < CH; c++) begin
            wr(c, 0, 0); wr(c, 1, 3000); wr(c, 2, 1);
        end
        settle(1000, 32'hFF, "all_on");
        ena = 1'b0;
        tick(1);
        check("ena_drop", 32'(ch_out), 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            seen |= round_done | (ch_out != '0);
        end
        check("ena_idle", 32'(seen), 32'h0);
        ena = 1'b1;
        tick(8);
        check("reena_rd_not_yet", 32'(round_done), 32'h0);
        tick(1);
        check("reena_rd", 32'(round_done), 32'h1);
        check("reena_out", 32'(ch_out), 32'hFF);
        tick(3);
        wr_valid = 1'b1;
        wr_addr  = 3'd0;
        wr_sel   = 2'd2;
        wr_data  = AW'(1);
        rst = 1'b0;
        #1;
        check("rst_mid_out", 32'(ch_out), 32'h0);
        check("rst_mid_rd", 32'(round_done), 32'h0);
        check("rst_mid_ready", 32'(wr_ready), 32'h1);
        tick(2);
        wr_valid = 1'b0;
        rst = 1'b1;
        seen  = 1'b0;
        seen4 = 1'b0;
        for (int k = 0; k < 2 * CH + 4; k++) begin
            tick(1);
            seen  |= (ch_out != '0);
            seen4 |= round_done;
        end
        check("post_rst_out", 32'(seen), 32'h0);
        check("post_rst_scan", 32'(seen4), 32'h1);
        wr(3, 0, 300); wr(3, 1, 300); wr(3, 2, 1);
        wr(4, 0, 300); wr(4, 1, 301); wr(4, 2, 1);
        seen  = 1'b0;
        seen4 = 1'b0;
        for (int a = 0; a <= 3839; a++) begin
            acnt = AW'(a);
            for (int k = 0; k < CH; k++) begin
                tick(1);
                seen  |= ch_out[3];
                seen4 |= ch_out[4];
            end
        end
        check("eq_never", 32'(seen), 32'h0);
        check("narrow_hit", 32'(seen4), 32'h1);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
